// File: rtl/stream_decypher.sv
// stream_decypher: receive-side keystream decipher with a small plaintext FIFO.
// The host loads a 16-bit key, pushes ciphertext bytes and pops plaintext.
// Command, strobe and status share the uio bus (TinyTapeout pin frame).
module stream_decypher #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] SEED_ZERO  = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] CMD_CLR  = 2'b00;
    localparam logic [1:0] CMD_LOAD = 2'b01;
    localparam logic [1:0] CMD_PUSH = 2'b10;
    localparam logic [1:0] CMD_POP  = 2'b11;

    localparam logic [15:0] TAPS = 16'hB400;

    typedef enum logic [1:0] {
        KEY_LO = 2'd0,
        KEY_HI = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t         state;
    logic [15:0]    key;
    logic [15:0]    lfsr;
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           err;
    logic [7:0]     mem [FIFO_DEPTH];

    logic           cmd_v;
    logic [1:0]     cmd;
    logic           empty;
    logic           full;
    logic           keyed;
    logic           wr_en;
    logic [15:0]    new_key;
    logic           unused_bits;

    // One Galois step: shift right, fold the taps back in when a 1 falls out.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        lfsr_step = l[0] ? ((l >> 1) ^ TAPS) : (l >> 1);
    endfunction

    // Eight steps unrolled so a whole keystream byte is consumed per push.
    function automatic logic [15:0] lfsr_adv8(input logic [15:0] l);
        logic [15:0] t;
        t = l;
        for (int i = 0; i < 8; i++) begin
            t = lfsr_step(t);
        end
        lfsr_adv8 = t;
    endfunction

    assign cmd_v   = ena & uio_in[3];
    assign cmd     = uio_in[1:0];
    assign keyed   = (state == RUN);
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign wr_en   = cmd_v && (cmd == CMD_PUSH) && keyed && !full;
    assign new_key = {ui_in, key[7:0]};

    assign uio_out = {keyed, err, full, empty, 4'b0000};
    assign uio_oe  = 8'hF0;

    // Only the command and strobe bits of uio_in carry meaning.
    assign unused_bits = ^{uio_in[7:4], uio_in[2]};

    // Plaintext storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[PTR_W-1:0]] <= ui_in ^ lfsr[7:0];
        end
    end

    // Command FSM: key loading, keystream advance, FIFO pointers, output and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= KEY_LO;
            key    <= 16'h0000;
            lfsr   <= SEED_ZERO;
            wr_ptr <= '0;
            rd_ptr <= '0;
            err    <= 1'b0;
            uo_out <= 8'h00;
        end else if (cmd_v) begin
            case (cmd)
                CMD_CLR: begin
                    err <= 1'b0;
                end
                CMD_LOAD: begin
                    if (state == KEY_HI) begin
                        // Second key byte: reseed, flush stale plaintext, start fresh.
                        key    <= new_key;
                        lfsr   <= (new_key == 16'h0000) ? SEED_ZERO : new_key;
                        rd_ptr <= wr_ptr;
                        err    <= 1'b0;
                        state  <= RUN;
                    end else begin
                        key[7:0] <= ui_in;
                        state    <= KEY_HI;
                    end
                end
                CMD_PUSH: begin
                    if (state == RUN) begin
                        // Keystream advances even on a dropped byte to stay in sync.
                        lfsr <= lfsr_adv8(lfsr);
                        if (full) begin
                            err <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end else begin
                        err <= 1'b1;
                    end
                end
                default: begin
                    if (empty) begin
                        err <= 1'b1;
                    end else begin
                        uo_out <= mem[rd_ptr[PTR_W-1:0]];
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_decypher.sv
// Bench for stream_decypher: directed scenarios with literal expectations plus a
// randomized command stream, all checked every cycle against a queue-based model.
module tb_stream_decypher;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena   = 1'b1;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    localparam logic [1:0] CLR  = 2'b00;
    localparam logic [1:0] LOAD = 2'b01;
    localparam logic [1:0] PUSH = 2'b10;
    localparam logic [1:0] POP  = 2'b11;

    stream_decypher #(.FIFO_DEPTH(4), .SEED_ZERO(16'hACE1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit live   = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0/1/2 = waiting for low key byte / high key byte / running.
    int          m_phase;
    logic [15:0] m_key;
    logic [15:0] m_lfsr;
    logic [7:0]  m_q [$];
    bit          m_err;
    logic [7:0]  m_uo;

    function automatic logic [15:0] next_byte_state(input logic [15:0] l);
        logic [15:0] t;
        t = l;
        repeat (8) t = t[0] ? ((t >> 1) ^ 16'hB400) : (t >> 1);
        return t;
    endfunction

    function automatic logic [7:0] m_status();
        return {m_phase == 2, m_err, m_q.size() == 4, m_q.size() == 0, 4'b0000};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_key   = 16'h0000;
            m_lfsr  = 16'hACE1;
            m_q.delete();
            m_err   = 1'b0;
            m_uo    = 8'h00;
        end else if (ena && uio_in[3]) begin
            case (uio_in[1:0])
                CLR: m_err = 1'b0;
                LOAD: begin
                    if (m_phase == 1) begin
                        m_key[15:8] = ui_in;
                        m_lfsr  = (m_key == 16'h0000) ? 16'hACE1 : m_key;
                        m_q.delete();
                        m_err   = 1'b0;
                        m_phase = 2;
                    end else begin
                        m_key[7:0] = ui_in;
                        m_phase    = 1;
                    end
                end
                PUSH: begin
                    if (m_phase == 2) begin
                        if (m_q.size() < 4) m_q.push_back(ui_in ^ m_lfsr[7:0]);
                        else m_err = 1'b1;
                        m_lfsr = next_byte_state(m_lfsr);
                    end else begin
                        m_err = 1'b1;
                    end
                end
                default: begin
                    if (m_q.size() > 0) m_uo = m_q.pop_front();
                    else m_err = 1'b1;
                end
            endcase
        end
    end

    // Every-cycle comparison, sampled on the inactive edge.
    always @(negedge clk) begin
        if (live) begin
            chk("cyc_uo_out", uo_out, m_uo);
            chk("cyc_uio_out", uio_out, m_status());
            chk("cyc_uio_oe", uio_oe, 8'hF0);
        end
    end

    task automatic do_cmd(input logic [1:0] c, input logic [7:0] d);
        @(negedge clk);
        ui_in  = d;
        uio_in = {4'b0000, 1'b1, 1'b0, c};
        @(negedge clk);
        uio_in = 8'h00;
    endtask

    task automatic load_key(input logic [15:0] k);
        do_cmd(LOAD, k[7:0]);
        do_cmd(LOAD, k[15:8]);
    endtask

    initial begin
        // Reset held for two cycles.
        repeat (2) @(negedge clk);
        chk("rst_uo_out", uo_out, 8'h00);
        chk("rst_uio_out", uio_out, 8'h10);
        chk("rst_uio_oe", uio_oe, 8'hF0);
        rst_n = 1'b1;
        live  = 1'b1;

        // Push/pop before keying.
        do_cmd(PUSH, 8'h55);
        chk("prekey_push_err", uio_out, 8'h50);
        do_cmd(POP, 8'h00);
        chk("prekey_pop_uo", uo_out, 8'h00);
        chk("prekey_pop_status", uio_out, 8'h50);
        do_cmd(CLR, 8'h00);
        chk("clr_err", uio_out, 8'h10);

        // Key 16'h0001: keystream bytes 01, 68.
        do_cmd(LOAD, 8'h01);
        chk("key_lo_status", uio_out, 8'h10);
        do_cmd(LOAD, 8'h00);
        chk("keyed_status", uio_out, 8'h90);
        do_cmd(PUSH, 8'h41);
        chk("push1_status", uio_out, 8'h80);
        do_cmd(POP, 8'h00);
        chk("pop1_plain", uo_out, 8'h40);
        chk("pop1_status", uio_out, 8'h90);
        do_cmd(PUSH, 8'h68);
        do_cmd(POP, 8'h00);
        chk("pop2_plain", uo_out, 8'h00);
        chk("pop2_status", uio_out, 8'h90);

        // Zero key falls back to seed ACE1 (first keystream byte E1).
        load_key(16'h0000);
        do_cmd(PUSH, 8'hBB);
        do_cmd(POP, 8'h00);
        chk("zero_key_plain_a", uo_out, 8'h5A);
        load_key(16'h0000);
        do_cmd(PUSH, 8'hE1);
        do_cmd(POP, 8'h00);
        chk("zero_key_plain_b", uo_out, 8'h00);

        // Overflow with key 0001.
        load_key(16'h0001);
        do_cmd(PUSH, 8'h41);
        do_cmd(PUSH, 8'h68);
        do_cmd(PUSH, 8'h11);
        do_cmd(PUSH, 8'h22);
        chk("full_status", uio_out, 8'hA0);
        do_cmd(PUSH, 8'h33);
        chk("overflow_err", uio_out, 8'hE0);
        do_cmd(POP, 8'h00);
        chk("ovf_pop1", uo_out, 8'h40);
        do_cmd(POP, 8'h00);
        chk("ovf_pop2", uo_out, 8'h00);
        do_cmd(POP, 8'h00);
        do_cmd(POP, 8'h00);
        chk("drained_status", uio_out, 8'hD0);
        do_cmd(POP, 8'h00);
        do_cmd(CLR, 8'h00);
        do_cmd(PUSH, 8'h9C);
        chk("after_drop_status", uio_out, 8'h80);
        do_cmd(POP, 8'h00);
        chk("after_drop_pop_status", uio_out, 8'h90);

        // ena low freezes everything.
        do_cmd(PUSH, 8'h12);
        do_cmd(PUSH, 8'h34);
        @(negedge clk);
        ena    = 1'b0;
        ui_in  = 8'h77;
        uio_in = {4'b0000, 1'b1, 1'b0, PUSH};
        repeat (3) @(negedge clk);
        uio_in = {4'b0000, 1'b1, 1'b0, POP};
        repeat (2) @(negedge clk);
        chk("ena_hold_status", uio_out, 8'h80);
        uio_in = 8'h00;
        ena    = 1'b1;

        // Asynchronous reset with two entries buffered.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_status", uio_out, 8'h10);
        chk("async_rst_uo", uo_out, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Rekey mid-stream flushes the FIFO.
        load_key(16'hBEEF);
        do_cmd(PUSH, 8'h01);
        do_cmd(PUSH, 8'h02);
        do_cmd(LOAD, 8'h5A);
        chk("rekey_keyhi_status", uio_out, 8'h00);
        do_cmd(LOAD, 8'hC3);
        chk("rekey_flush_status", uio_out, 8'h90);

        // Randomized back-to-back command stream.
        for (int i = 0; i < 600; i++) begin
            int         r;
            logic [1:0] c;
            logic [7:0] u;
            @(negedge clk);
            r   = $urandom_range(0, 99);
            ena = ($urandom_range(0, 19) != 0);
            if (r < 40)      c = PUSH;
            else if (r < 75) c = POP;
            else if (r < 83) c = LOAD;
            else             c = CLR;
            u      = 8'($urandom);
            u[3]   = ($urandom_range(0, 9) != 0);
            u[1:0] = c;
            uio_in = u;
            ui_in  = 8'($urandom);
        end
        @(negedge clk);
        uio_in = 8'h00;
        ena    = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
